memories_channel_bank: RTL and testbench
========================================

Name: memories_channel_bank

Overview:
- Parametrised successor to the fixed 3-channel input memory block. Buffers NUM_CHANNELS feature-map channels streamed serially, one channel after another.
- Replays all channels in lockstep so the convolution datapath sees one word per channel per read.
- Adds per-channel fill tracking, overflow detection and a last-word marker.
- Sits between the host/DMA input stream and the convolution engine.

Parameters:
- DATA_WIDTH, 16, word width.
- NUM_CHANNELS, 3, channel count (2..16).
- CH_SEL_WIDTH, 2, channel index width, >= clog2(NUM_CHANNELS).
- ADDR_WIDTH, 16, per-channel address width.
- MEM_DEPTH, 65536, words per channel, <= 2**ADDR_WIDTH.

Ports:
- MEMORIES_BANK_Clk, in, 1: single clock, rising edge.
- MEMORIES_BANK_Reset, in, 1: reset, synchronous, active-high.
- MEMORIES_BANK_Start, in, 1: pulse; begin a new load.
- MEMORIES_BANK_Wr_Valid, in, 1: write Wr_Data into the current channel.
- MEMORIES_BANK_Wr_Data, in, DATA_WIDTH: input word.
- MEMORIES_BANK_New_Channel_Flag, in, 1: pulse; close the current channel.
- MEMORIES_BANK_Rd_Start, in, 1: pulse; enter the output routine and rewind reads.
- MEMORIES_BANK_Re, in, 1: read the next word from all channels.
- MEMORIES_BANK_Rd_Data, out, NUM_CHANNELS*DATA_WIDTH: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- MEMORIES_BANK_Rd_Valid, out, 1: Rd_Data is valid.
- MEMORIES_BANK_Rd_Last, out, 1: qualifies the final word of a replay.
- MEMORIES_BANK_Wr_Channel, out, CH_SEL_WIDTH: channel currently being written.
- MEMORIES_BANK_Load_Done, out, 1: all channels loaded.
- MEMORIES_BANK_Overflow, out, 1: sticky; a write was dropped.
- MEMORIES_BANK_State, out, 2: IDLE=0, LOAD=1, READY=2, READ=3.

Behaviour:
- Reset, synchronous and active-high, wins over every other input.
  - State goes to IDLE.
  - All outputs are 0.
  - Write channel, all write pointers, fill counts and the read pointer are 0.
  - RAM contents are untouched but logically discarded.
  - Reset during LOAD or READ aborts immediately; no further Rd_Valid.
- Start is honoured in any state.
  - Clears pointers, fills, Overflow, Load_Done and Wr_Channel, then enters LOAD.
  - Start and Wr_Valid in the same cycle: the write is ignored.
- LOAD, on Wr_Valid:
  - If fill[ch] < MEM_DEPTH: write mem[ch][fill[ch]] and increment fill[ch].
  - Otherwise drop the word and set Overflow, which stays set until Start or reset.
- LOAD, on New_Channel_Flag: advance Wr_Channel.
  - Wr_Valid in the same cycle writes to the old channel first.
  - When the flag arrives on channel NUM_CHANNELS-1: enter READY, set Load_Done=1, and keep Wr_Channel at NUM_CHANNELS-1.
- Outside LOAD, Wr_Valid and New_Channel_Flag are ignored.
- READY, on Rd_Start: rptr=0, enter READ.
  - Rd_Start is ignored if every fill is 0.
- READ, on Re: all channels read address rptr in parallel and rptr increments.
  - Rd_Valid is asserted exactly 1 cycle after each Re; Re may be held high for back-to-back reads.
  - Channel k outputs 0 when rptr >= fill[k] (zero-pad for short channels).
  - L = max(fill[k]). Rd_Last is asserted with the word for rptr == L-1.
  - The FSM returns to READY on the Re that reads L-1; any further Re is ignored.
  - Re in any state other than READ is ignored.
- Replay: data persists, so Rd_Start from READY replays identically.
  - Rd_Start during READ restarts the replay at rptr=0.
- Rd_Data holds its last value when Rd_Valid=0.

Optional Feature:
- Macro: MEMORIES_BANK_RD_REG_EN.
- Defined: adds an output register stage on Rd_Data, Rd_Valid and Rd_Last. Read latency becomes 2 cycles; the pipeline stays fully streaming.
  - Reset also clears the stage.
  - Start or Rd_Start flushes the in-flight word (Rd_Valid is not asserted for it).
- Undefined: read latency is 1 cycle, as described above.

Test Plan:
- Basic load and read. Stimulus: reset; Start; load 4 words per channel (ch0 0x0001..0x0004, ch1 0x0101.., ch2 0x0201..); New_Channel_Flag x3; Rd_Start; Re held 4 cycles. Response: Load_Done=1; Rd_Valid 1 cycle after each Re; words {0x0201,0x0101,0x0001}..{0x0204,0x0104,0x0004}; Rd_Last on the 4th word only; State returns to 2.
- Unequal fills. Stimulus: ch0=5, ch1=2, ch2=3 words. Response: 5 outputs; ch1 lane is 0 on words 3-5 and ch2 lane is 0 on words 4-5; Rd_Last on word 5.
- Overflow. Stimulus: MEM_DEPTH=8; write 10 words to ch0. Response: Overflow=1 after the 9th write; fill0=8; replay of words 1-8 is intact.
- Simultaneous events. Stimulus: Wr_Valid together with New_Channel_Flag on the last channel. Response: the word is stored in the last channel and State=READY the next cycle. Separately, Start together with Wr_Valid: no write, State=LOAD.
- Reset mid-read. Stimulus: Reset asserted after 2 of 4 reads. Response: next cycle all outputs are 0 and State=0; a subsequent Rd_Start is ignored.
- Replay with option. Stimulus: second Rd_Start after a replay with MEMORIES_BANK_RD_REG_EN defined. Response: identical data stream at 2-cycle latency.

Source files
------------

// File: rtl/memories_channel_bank.sv
// Multi-channel input buffer: serial per-channel load, lockstep parallel replay with zero padding.
// Optional output register stage enabled by defining MEMORIES_BANK_RD_REG_EN.
module memories_channel_bank #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 3,
    parameter int CH_SEL_WIDTH = 2,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEM_DEPTH    = 65536
) (
    input  logic                               MEMORIES_BANK_Clk,
    input  logic                               MEMORIES_BANK_Reset,
    input  logic                               MEMORIES_BANK_Start,
    input  logic                               MEMORIES_BANK_Wr_Valid,
    input  logic [DATA_WIDTH-1:0]              MEMORIES_BANK_Wr_Data,
    input  logic                               MEMORIES_BANK_New_Channel_Flag,
    input  logic                               MEMORIES_BANK_Rd_Start,
    input  logic                               MEMORIES_BANK_Re,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] MEMORIES_BANK_Rd_Data,
    output logic                               MEMORIES_BANK_Rd_Valid,
    output logic                               MEMORIES_BANK_Rd_Last,
    output logic [CH_SEL_WIDTH-1:0]            MEMORIES_BANK_Wr_Channel,
    output logic                               MEMORIES_BANK_Load_Done,
    output logic                               MEMORIES_BANK_Overflow,
    output logic [1:0]                         MEMORIES_BANK_State
);

    // Fill counters need one extra bit so a completely full channel is representable.
    localparam int FILL_W = ADDR_WIDTH + 1;
    localparam logic [FILL_W-1:0]       DEPTH_C   = FILL_W'(MEM_DEPTH);
    localparam logic [CH_SEL_WIDTH-1:0] LAST_CH_C = CH_SEL_WIDTH'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t                              state;
    logic [DATA_WIDTH-1:0]               mem [NUM_CHANNELS][MEM_DEPTH];
    logic [FILL_W-1:0]                   fill [NUM_CHANNELS];
    logic [CH_SEL_WIDTH-1:0]             wr_ch;
    logic [FILL_W-1:0]                   rptr;
    logic [FILL_W-1:0]                   max_fill;
    logic [FILL_W-1:0]                   last_idx;
    logic [FILL_W-1:0]                   cur_fill;
    logic                                any_fill;
    logic                                wr_en;
    logic                                overflow;
    logic                                load_done;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]  rd_data_p1;
    logic                                vld_p1;
    logic                                last_p1;

    assign cur_fill = fill[wr_ch];
    assign wr_en    = !MEMORIES_BANK_Reset && !MEMORIES_BANK_Start && (state == LOAD)
                      && MEMORIES_BANK_Wr_Valid && (cur_fill < DEPTH_C);

    always_comb begin
        max_fill = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (fill[k] > max_fill) max_fill = fill[k];
        end
    end

    assign any_fill = (max_fill != '0);
    assign last_idx = max_fill - FILL_W'(1);

    // RAM write port kept free of reset so it maps onto block memory.
    always_ff @(posedge MEMORIES_BANK_Clk) begin
        if (wr_en) mem[wr_ch][cur_fill[ADDR_WIDTH-1:0]] <= MEMORIES_BANK_Wr_Data;
    end

    // Stage p1: control FSM and registered parallel read.
    always_ff @(posedge MEMORIES_BANK_Clk) begin
        if (MEMORIES_BANK_Reset) begin
            state      <= IDLE;
            wr_ch      <= '0;
            rptr       <= '0;
            overflow   <= 1'b0;
            load_done  <= 1'b0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            rd_data_p1 <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++) fill[k] <= '0;
        end else begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            if (MEMORIES_BANK_Start) begin
                state     <= LOAD;
                wr_ch     <= '0;
                rptr      <= '0;
                overflow  <= 1'b0;
                load_done <= 1'b0;
                for (int k = 0; k < NUM_CHANNELS; k++) fill[k] <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        if (MEMORIES_BANK_Wr_Valid) begin
                            if (cur_fill < DEPTH_C) fill[wr_ch] <= cur_fill + FILL_W'(1);
                            else                    overflow    <= 1'b1;
                        end
                        if (MEMORIES_BANK_New_Channel_Flag) begin
                            if (wr_ch == LAST_CH_C) begin
                                state     <= READY;
                                load_done <= 1'b1;
                            end else begin
                                wr_ch <= wr_ch + CH_SEL_WIDTH'(1);
                            end
                        end
                    end
                    READY: begin
                        if (MEMORIES_BANK_Rd_Start && any_fill) begin
                            rptr  <= '0;
                            state <= READ;
                        end
                    end
                    READ: begin
                        if (MEMORIES_BANK_Rd_Start) begin
                            rptr <= '0;
                        end else if (MEMORIES_BANK_Re) begin
                            // Lanes past their own fill are padded with zero.
                            for (int k = 0; k < NUM_CHANNELS; k++) begin
                                rd_data_p1[k*DATA_WIDTH +: DATA_WIDTH] <=
                                    (rptr < fill[k]) ? mem[k][rptr[ADDR_WIDTH-1:0]] : '0;
                            end
                            vld_p1  <= 1'b1;
                            last_p1 <= (rptr == last_idx);
                            rptr    <= rptr + FILL_W'(1);
                            if (rptr == last_idx) state <= READY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MEMORIES_BANK_RD_REG_EN
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] rd_data_p2;
    logic                               vld_p2;
    logic                               last_p2;
    logic                               flush;

    assign flush = MEMORIES_BANK_Start || MEMORIES_BANK_Rd_Start;

    // Stage p2: output register; a new load or replay drops the word in flight.
    always_ff @(posedge MEMORIES_BANK_Clk) begin
        if (MEMORIES_BANK_Reset) begin
            vld_p2     <= 1'b0;
            last_p2    <= 1'b0;
            rd_data_p2 <= '0;
        end else begin
            vld_p2  <= vld_p1 && !flush;
            last_p2 <= last_p1 && !flush;
            if (vld_p1 && !flush) rd_data_p2 <= rd_data_p1;
        end
    end

    assign MEMORIES_BANK_Rd_Data  = rd_data_p2;
    assign MEMORIES_BANK_Rd_Valid = vld_p2;
    assign MEMORIES_BANK_Rd_Last  = last_p2;
`else
    assign MEMORIES_BANK_Rd_Data  = rd_data_p1;
    assign MEMORIES_BANK_Rd_Valid = vld_p1;
    assign MEMORIES_BANK_Rd_Last  = last_p1;
`endif

    assign MEMORIES_BANK_Wr_Channel = wr_ch;
    assign MEMORIES_BANK_Load_Done  = load_done;
    assign MEMORIES_BANK_Overflow   = overflow;
    assign MEMORIES_BANK_State      = state;

endmodule

// File: tb/tb_memories_channel_bank.sv
// Self-checking bench for memories_channel_bank against a queue-based reference model.
module tb_memories_channel_bank;

`ifdef MEMORIES_BANK_RD_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 8;

    logic        clk, rst, start, wr_valid, new_ch, rd_start, re;
    logic [15:0] wr_data;
    logic [47:0] rd_data;
    logic        rd_valid, rd_last, load_done, overflow;
    logic [1:0]  wr_channel, state;

    int passed = 0;
    int total  = 0;

    logic [15:0] mq [3][$];
    logic [47:0] cap_d [$];
    logic        cap_l [$];
    int          cap_c [$];

    memories_channel_bank #(
        .DATA_WIDTH(16), .NUM_CHANNELS(3), .CH_SEL_WIDTH(2), .ADDR_WIDTH(3), .MEM_DEPTH(DEPTH)
    ) dut (
        .MEMORIES_BANK_Clk(clk),
        .MEMORIES_BANK_Reset(rst),
        .MEMORIES_BANK_Start(start),
        .MEMORIES_BANK_Wr_Valid(wr_valid),
        .MEMORIES_BANK_Wr_Data(wr_data),
        .MEMORIES_BANK_New_Channel_Flag(new_ch),
        .MEMORIES_BANK_Rd_Start(rd_start),
        .MEMORIES_BANK_Re(re),
        .MEMORIES_BANK_Rd_Data(rd_data),
        .MEMORIES_BANK_Rd_Valid(rd_valid),
        .MEMORIES_BANK_Rd_Last(rd_last),
        .MEMORIES_BANK_Wr_Channel(wr_channel),
        .MEMORIES_BANK_Load_Done(load_done),
        .MEMORIES_BANK_Overflow(overflow),
        .MEMORIES_BANK_State(state)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_len();
        int m = 0;
        for (int k = 0; k < 3; k++) if (mq[k].size() > m) m = mq[k].size();
        return m;
    endfunction

    function automatic logic [47:0] exp_word(input int w);
        logic [47:0] r = '0;
        for (int k = 0; k < 3; k++) r[k*16 +: 16] = (w < mq[k].size()) ? mq[k][w] : 16'h0;
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) mq[k].delete();
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
        model_clear();
    endtask

    task automatic pulse_rd_start();
        rd_start = 1; tick(); rd_start = 0;
    endtask

    task automatic close_channel();
        new_ch = 1; tick(); new_ch = 0;
    endtask

    task automatic load(input int n0, input int n1, input int n2, input bit pat, input bit merge);
        int n [3];
        n = '{n0, n1, n2};
        pulse_start();
        for (int ch = 0; ch < 3; ch++) begin
            for (int i = 0; i < n[ch]; i++) begin
                wr_valid = 1;
                wr_data  = pat ? 16'(ch * 256 + i + 1) : 16'($urandom);
                new_ch   = merge && (i == n[ch] - 1);
                if (mq[ch].size() < DEPTH) mq[ch].push_back(wr_data);
                tick();
            end
            wr_valid = 0;
            new_ch   = 0;
            if (!(merge && n[ch] > 0)) close_channel();
        end
    endtask

    task automatic do_read(input int n);
        cap_d.delete(); cap_l.delete(); cap_c.delete();
        re = 1;
        for (int c = 1; c <= n + LAT + 1; c++) begin
            tick();
            if (c == n) re = 0;
            if (rd_valid === 1'b1) begin
                cap_d.push_back(rd_data);
                cap_l.push_back(rd_last);
                cap_c.push_back(c);
            end
        end
        re = 0;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; wr_valid = 0; wr_data = 0; new_ch = 0; rd_start = 0; re = 0;
        tick(); tick();
        rst = 0;
        total++; if (state !== 2'd0) $display("FAIL reset_state: got %0d exp 0", state); else passed++;
        total++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) $display("FAIL reset_rd_flags: got %b%b exp 00", rd_valid, rd_last); else passed++;
        total++; if (rd_data !== 48'h0) $display("FAIL reset_rd_data: got %h exp 0", rd_data); else passed++;
        total++; if (wr_channel !== 2'd0 || load_done !== 1'b0 || overflow !== 1'b0)
            $display("FAIL reset_status: got ch=%0d done=%b ovf=%b exp 0 0 0", wr_channel, load_done, overflow); else passed++;
    endtask

    task automatic test_basic();
        load(4, 4, 4, 1'b1, 1'b0);
        total++; if (load_done !== 1'b1) $display("FAIL basic_load_done: got %b exp 1", load_done); else passed++;
        total++; if (state !== 2'd2) $display("FAIL basic_ready: got %0d exp 2", state); else passed++;
        total++; if (wr_channel !== 2'd2) $display("FAIL basic_wr_channel: got %0d exp 2", wr_channel); else passed++;
        pulse_rd_start();
        total++; if (state !== 2'd3) $display("FAIL basic_read_state: got %0d exp 3", state); else passed++;
        do_read(4);
        total++; if (cap_d.size() != 4) $display("FAIL basic_count: got %0d exp 4", cap_d.size()); else passed++;
        for (int w = 0; w < cap_d.size() && w < 4; w++) begin
            total++; if (cap_d[w] !== exp_word(w)) $display("FAIL basic_data%0d: got %h exp %h", w, cap_d[w], exp_word(w)); else passed++;
            total++; if (cap_l[w] !== (w == 3)) $display("FAIL basic_last%0d: got %b exp %b", w, cap_l[w], w == 3); else passed++;
            total++; if (cap_c[w] != w + LAT) $display("FAIL basic_latency%0d: got %0d exp %0d", w, cap_c[w], w + LAT); else passed++;
        end
        total++; if (state !== 2'd2) $display("FAIL basic_back_to_ready: got %0d exp 2", state); else passed++;
    endtask

    task automatic test_unequal();
        load(5, 2, 3, 1'b0, 1'b0);
        pulse_rd_start();
        do_read(5);
        total++; if (cap_d.size() != 5) $display("FAIL unequal_count: got %0d exp 5", cap_d.size()); else passed++;
        for (int w = 0; w < cap_d.size() && w < 5; w++) begin
            total++; if (cap_d[w] !== exp_word(w)) $display("FAIL unequal_data%0d: got %h exp %h", w, cap_d[w], exp_word(w)); else passed++;
            total++; if (cap_l[w] !== (w == 4)) $display("FAIL unequal_last%0d: got %b exp %b", w, cap_l[w], w == 4); else passed++;
        end
    endtask

    task automatic test_overflow();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1;
            wr_data  = 16'($urandom);
            if (mq[0].size() < DEPTH) mq[0].push_back(wr_data);
            tick();
            if (i == 7) begin
                total++; if (overflow !== 1'b0) $display("FAIL ovf_at_full: got %b exp 0", overflow); else passed++;
            end
            if (i == 8) begin
                total++; if (overflow !== 1'b1) $display("FAIL ovf_after_9th: got %b exp 1", overflow); else passed++;
            end
        end
        wr_valid = 0;
        close_channel(); close_channel(); close_channel();
        total++; if (overflow !== 1'b1 || load_done !== 1'b1)
            $display("FAIL ovf_sticky: got ovf=%b done=%b exp 1 1", overflow, load_done); else passed++;
        pulse_rd_start();
        do_read(10);
        total++; if (cap_d.size() != DEPTH) $display("FAIL ovf_count: got %0d exp %0d", cap_d.size(), DEPTH); else passed++;
        for (int w = 0; w < cap_d.size() && w < DEPTH; w++) begin
            total++; if (cap_d[w] !== exp_word(w)) $display("FAIL ovf_data%0d: got %h exp %h", w, cap_d[w], exp_word(w)); else passed++;
        end
        pulse_start();
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clear_on_start: got %b exp 0", overflow); else passed++;
    endtask

    task automatic test_simultaneous();
        load(3, 2, 4, 1'b0, 1'b1);
        total++; if (state !== 2'd2) $display("FAIL simul_ready: got %0d exp 2", state); else passed++;
        pulse_rd_start();
        do_read(4);
        total++; if (cap_d.size() != 4) $display("FAIL simul_count: got %0d exp 4", cap_d.size()); else passed++;
        for (int w = 0; w < cap_d.size() && w < 4; w++) begin
            total++; if (cap_d[w] !== exp_word(w)) $display("FAIL simul_data%0d: got %h exp %h", w, cap_d[w], exp_word(w)); else passed++;
        end
        start = 1; wr_valid = 1; wr_data = 16'hBEEF;
        tick();
        start = 0; wr_valid = 0;
        model_clear();
        total++; if (state !== 2'd1 || wr_channel !== 2'd0 || load_done !== 1'b0)
            $display("FAIL start_wr_state: got st=%0d ch=%0d done=%b exp 1 0 0", state, wr_channel, load_done); else passed++;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1; wr_data = 16'(16'h4000 + i);
            mq[0].push_back(wr_data);
            tick();
        end
        wr_valid = 0;
        close_channel(); close_channel(); close_channel();
        pulse_rd_start();
        do_read(2);
        total++; if (cap_d.size() != 2) $display("FAIL start_wr_count: got %0d exp 2", cap_d.size()); else passed++;
        for (int w = 0; w < cap_d.size() && w < 2; w++) begin
            total++; if (cap_d[w] !== exp_word(w)) $display("FAIL start_wr_data%0d: got %h exp %h", w, cap_d[w], exp_word(w)); else passed++;
        end
    endtask

    task automatic test_empty_load();
        load(0, 0, 0, 1'b0, 1'b0);
        total++; if (state !== 2'd2) $display("FAIL empty_ready: got %0d exp 2", state); else passed++;
        pulse_rd_start();
        total++; if (state !== 2'd2) $display("FAIL empty_rd_start_ignored: got %0d exp 2", state); else passed++;
        re = 1; tick(); tick(); re = 0;
        total++; if (rd_valid !== 1'b0) $display("FAIL empty_no_valid: got %b exp 0", rd_valid); else passed++;
    endtask

    task automatic test_replay();
        logic [47:0] first [$];
        load(2, 6, 1, 1'b0, 1'b0);
        pulse_rd_start();
        do_read(8);
        total++; if (cap_d.size() != 6) $display("FAIL replay1_count: got %0d exp 6", cap_d.size()); else passed++;
        for (int w = 0; w < cap_d.size() && w < 6; w++) begin
            total++; if (cap_d[w] !== exp_word(w)) $display("FAIL replay1_data%0d: got %h exp %h", w, cap_d[w], exp_word(w)); else passed++;
            total++; if (cap_l[w] !== (w == 5)) $display("FAIL replay1_last%0d: got %b exp %b", w, cap_l[w], w == 5); else passed++;
        end
        total++; if (state !== 2'd2) $display("FAIL replay1_ready: got %0d exp 2", state); else passed++;
        pulse_rd_start();
        re = 1; tick(); tick(); re = 0;
        pulse_rd_start();
        total++; if (state !== 2'd3) $display("FAIL restart_state: got %0d exp 3", state); else passed++;
        do_read(6);
        total++; if (cap_d.size() != 6) $display("FAIL replay2_count: got %0d exp 6", cap_d.size()); else passed++;
        for (int w = 0; w < cap_d.size() && w < 6; w++) begin
            total++; if (cap_d[w] !== exp_word(w)) $display("FAIL replay2_data%0d: got %h exp %h", w, cap_d[w], exp_word(w)); else passed++;
            total++; if (cap_c[w] != w + LAT) $display("FAIL replay2_latency%0d: got %0d exp %0d", w, cap_c[w], w + LAT); else passed++;
        end
    endtask

    task automatic test_reset_mid_read();
        load(4, 4, 4, 1'b0, 1'b0);
        pulse_rd_start();
        re = 1; tick(); tick();
        rst = 1;
        tick();
        rst = 0; re = 0;
        total++; if (state !== 2'd0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 48'h0)
            $display("FAIL midread_reset_out: got st=%0d v=%b l=%b d=%h exp 0 0 0 0", state, rd_valid, rd_last, rd_data); else passed++;
        total++; if (load_done !== 1'b0 || overflow !== 1'b0 || wr_channel !== 2'd0)
            $display("FAIL midread_reset_status: got done=%b ovf=%b ch=%0d exp 0 0 0", load_done, overflow, wr_channel); else passed++;
        pulse_rd_start();
        total++; if (state !== 2'd0) $display("FAIL midread_rd_start_ignored: got %0d exp 0", state); else passed++;
        re = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (rd_valid !== 1'b0) $display("FAIL midread_no_valid%0d: got %b exp 0", i, rd_valid); else passed++;
        end
        re = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unequal();
        test_overflow();
        test_simultaneous();
        test_empty_load();
        test_replay();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
